wb_load_sequencer: RTL and testbench
====================================

# wb_load_sequencer

Wishbone master controller that bulk-loads rows from a host-side word buffer into the GPU's Wishbone slave load port. It issues one CYC_O bracket per destination row, tagged as instruction or data. Inside each bracket it sends 3 write beats for a data row or 2 for an instruction row. It then pulses MST_O with CYC_O low so the slave commits the row, and repeats until the requested row count is written.

## Interface
- TIMEOUT_CYCLES, 255: BEAT cycles without ACK_I before abort (used only with WBM_TIMEOUT_EN)
- CLK_I  in  1  single clock
- RST_I  in  1  synchronous, active-high reset
- iStart  in  1  start pulse; sampled only in IDLE
- iType  in  1  0 = data row (3 beats, TGA 2'b01); 1 = instruction row (2 beats, TGA 2'b10)
- iDestBase  in  16  first destination row address
- iRowCount  in  16  rows to load; 0 is legal
- iSrcBase  in  16  first source word address
- oSrcAddress  out  16  source buffer read address
- iSrcData  in  32  source word, valid 1 cycle after oSrcAddress
- CYC_O, STB_O, WE_O, MST_O  out  1 each  Wishbone controls
- ADR_O  out  32  {16'h0, row address}
- TGA_O  out  2  address tag
- DAT_O  out  32  beat data
- ACK_I  in  1  slave acknowledge
- oBusy  out  1  transfer in progress
- oDone  out  1  one-cycle completion pulse
- oError  out  1  timeout abort; sticky until the next accepted iStart

## Operation
- iStart, iType, iDestBase, iRowCount and iSrcBase are captured in IDLE. An iStart while not in IDLE is ignored.
- States:
  - IDLE: on iStart go to CYC_OPEN, or to DONE if iRowCount = 0.
  - CYC_OPEN: CYC_O=1; ADR_O and TGA_O driven; go to FETCH.
  - FETCH: oSrcAddress driven; DAT_O loaded from iSrcData at the end of the following cycle; go to BEAT.
  - BEAT: STB_O=WE_O=1 until ACK_I is sampled high.
  - After ACK_I: go to FETCH if beats remain in the row, otherwise to CLOSE.
  - CLOSE: CYC_O=0 and MST_O=1 for exactly one cycle; go to CYC_OPEN if rows remain, otherwise to DONE.
  - DONE: oDone=1; go to IDLE.
- MST_O is high only in CLOSE. A commit never occurs outside CLOSE.
- Row r address is (iDestBase + r) mod 2^16. Source word addresses run iSrcBase, iSrcBase+1, … one per beat, mod 2^16.
- ADR_O, TGA_O and CYC_O are stable for the whole bracket.
- DAT_O holds its value while STB_O waits for ACK_I.
- Row and beat counters are 16 and 2 bits; the row counter compares against the captured iRowCount.
- oBusy = 1 in every state except IDLE and DONE.

## Timing
- Reset: all outputs 0 on the next edge and state forced to IDLE, including mid-transfer. No MST_O pulse is emitted; the partial row is dropped.
- iStart sampled at edge 0. CYC_OPEN runs in cycle 1 and the first FETCH in cycle 2.
- With a slave that ACKs 1 cycle after STB: each beat takes 3 cycles (FETCH plus 2 BEAT cycles), CLOSE takes 1.
  - Data row: 11 cycles. Instruction row: 8 cycles.
  - oDone in cycle 11N+1 (data) or 8N+1 (instruction) after iStart.
- iRowCount = 0: oDone in cycle 1; CYC_O never asserted.
- STB_O drops in the cycle after ACK_I is sampled high. An ACK_I outside BEAT is ignored.
- A new iStart is accepted no earlier than the cycle after oDone.

## Configuration
- WBM_TIMEOUT_EN defined:
  - A counter runs in BEAT and clears on each FETCH.
  - When it reaches TIMEOUT_CYCLES, STB_O, WE_O and CYC_O drop, with no MST_O pulse.
  - oError is set and the block goes to DONE (oDone pulses).
- WBM_TIMEOUT_EN undefined: BEAT waits indefinitely; oError is tied to 0.

## Structure
- Shared package/include holds:
  - tag constants for instruction (2'b10) and data (2'b01)
  - beats-per-row constants (2, 3)
  - state encodings
  - the 16-bit address width
- Sub-module wbm_ack_watchdog holds the timeout counter. It is instantiated only under WBM_TIMEOUT_EN.

## Test plan
- Data load, iDestBase=0x0010, iRowCount=1, source {A,B,C}:
  - ADR_O=0x10 and TGA_O=01 across the bracket
  - DAT_O carries A, B, C in order
  - one MST_O cycle with CYC_O=0
  - oDone at cycle 12
- Instruction load, iRowCount=2, iDestBase=0, iSrcBase=0:
  - ADR_O 0x0 then 0x1, TGA_O=10
  - oSrcAddress 0,1,2,3
  - two MST_O pulses
  - oDone at cycle 17
- iRowCount=0 -> oDone at cycle 1, CYC_O stays 0, oBusy stays 0.
- ACK_I held off for 5 cycles on beat 2 -> STB_O and DAT_O stable throughout; STB_O drops the cycle after ACK_I.
- RST_I asserted mid-BEAT of row 1 -> all outputs 0 next edge, no MST_O pulse; a fresh iStart then runs normally.
- WBM_TIMEOUT_EN with ACK_I never asserted ->
  - after 255 BEAT cycles CYC_O and STB_O drop
  - oError=1, oDone pulses, no MST_O
  - the next iStart clears oError.

Source files
------------

// File: rtl/wb_load_sequencer_pkg.sv
// Shared constants for wb_load_sequencer: row tags, beats per row, FSM encoding
// and the address width used by the host buffer and the row addresses.
package wb_load_sequencer_pkg;

  localparam int ADDR_W = 16;

  localparam logic [1:0] TAG_INSTR   = 2'b10;
  localparam logic [1:0] TAG_DATA    = 2'b01;
  localparam logic [1:0] BEATS_INSTR = 2'd2;
  localparam logic [1:0] BEATS_DATA  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CYC_OPEN = 3'd1,
    ST_FETCH    = 3'd2,
    ST_BEAT     = 3'd3,
    ST_CLOSE    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic logic [1:0] row_tag(input logic is_instr);
    row_tag = is_instr ? TAG_INSTR : TAG_DATA;
  endfunction

  // Index of the final beat in a row, matched against the 2-bit beat counter.
  function automatic logic [1:0] last_beat(input logic is_instr);
    last_beat = (is_instr ? BEATS_INSTR : BEATS_DATA) - 2'd1;
  endfunction

endpackage

// File: rtl/wbm_ack_watchdog.sv
// Counts consecutive BEAT cycles and flags the cycle in which the wait for
// ACK_I has lasted TIMEOUT_CYCLES; used only when WBM_TIMEOUT_EN is defined.
module wbm_ack_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic beat_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // BEAT-cycle counter; every non-BEAT cycle (each FETCH included) clears it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!beat_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST_CNT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expire_o = beat_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/wb_load_sequencer.sv
// Wishbone master that copies host-buffer words into GPU rows, one CYC_O bracket
// and one MST_O commit per row. Define WBM_TIMEOUT_EN to abort an unanswered beat.
module wb_load_sequencer
  import wb_load_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              iStart,
  input  logic              iType,
  input  logic [ADDR_W-1:0] iDestBase,
  input  logic [ADDR_W-1:0] iRowCount,
  input  logic [ADDR_W-1:0] iSrcBase,
  output logic [ADDR_W-1:0] oSrcAddress,
  input  logic [31:0]       iSrcData,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic              MST_O,
  output logic [31:0]       ADR_O,
  output logic [1:0]        TGA_O,
  output logic [31:0]       DAT_O,
  input  logic              ACK_I,
  output logic              oBusy,
  output logic              oDone,
  output logic              oError
);

  state_e            state_q;
  logic              type_q;
  logic [ADDR_W-1:0] dest_q;
  logic [ADDR_W-1:0] rows_q;
  logic [ADDR_W-1:0] row_cnt_q;
  logic [ADDR_W-1:0] src_next_q;
  logic [ADDR_W-1:0] src_addr_q;
  logic [ADDR_W-1:0] adr_q;
  logic [1:0]        beat_cnt_q;
  logic [1:0]        tga_q;
  logic [31:0]       dat_q;
  logic              cyc_q;
  logic              stb_q;
  logic              we_q;
  logic              mst_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              load_pend_q;
  logic              timeout_s;

`ifdef WBM_TIMEOUT_EN
  wbm_ack_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (CLK_I),
    .rst_i   (RST_I),
    .beat_i  (state_q == ST_BEAT),
    .expire_o(timeout_s)
  );
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYCLES != 32'sd0);
  assign timeout_s = 1'b0;
`endif

  // Sequencer FSM; every bus output is registered alongside the state it belongs to
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= ST_IDLE;
      type_q      <= 1'b0;
      dest_q      <= '0;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      src_next_q  <= '0;
      src_addr_q  <= '0;
      adr_q       <= '0;
      beat_cnt_q  <= 2'd0;
      tga_q       <= 2'b00;
      dat_q       <= 32'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      mst_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      mst_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            type_q     <= iType;
            dest_q     <= iDestBase;
            rows_q     <= iRowCount;
            src_next_q <= iSrcBase;
            row_cnt_q  <= '0;
            err_q      <= 1'b0;
            if (iRowCount == 16'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_CYC_OPEN;
              cyc_q   <= 1'b1;
              busy_q  <= 1'b1;
              adr_q   <= iDestBase;
              tga_q   <= row_tag(iType);
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CYC_OPEN: begin
          state_q    <= ST_FETCH;
          beat_cnt_q <= 2'd0;
          src_addr_q <= src_next_q;
          src_next_q <= src_next_q + 16'd1;
        end
        ST_FETCH: begin
          state_q     <= ST_BEAT;
          stb_q       <= 1'b1;
          we_q        <= 1'b1;
          load_pend_q <= 1'b1;
        end
        ST_BEAT: begin
          // The source word arrives during the first BEAT cycle; later cycles hold it.
          if (load_pend_q) begin
            dat_q       <= iSrcData;
            load_pend_q <= 1'b0;
          end else begin
            dat_q <= dat_q;
          end
          if (ACK_I) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (beat_cnt_q == last_beat(type_q)) begin
              state_q   <= ST_CLOSE;
              cyc_q     <= 1'b0;
              mst_q     <= 1'b1;
              row_cnt_q <= row_cnt_q + 16'd1;
            end else begin
              state_q    <= ST_FETCH;
              beat_cnt_q <= beat_cnt_q + 2'd1;
              src_addr_q <= src_next_q;
              src_next_q <= src_next_q + 16'd1;
            end
          end else if (timeout_s) begin
            state_q     <= ST_DONE;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b1;
            done_q      <= 1'b1;
            load_pend_q <= 1'b0;
          end else begin
            state_q <= ST_BEAT;
          end
        end
        ST_CLOSE: begin
          if (row_cnt_q == rows_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_CYC_OPEN;
            cyc_q   <= 1'b1;
            adr_q   <= dest_q + row_cnt_q;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oSrcAddress = src_addr_q;
  assign CYC_O       = cyc_q;
  assign STB_O       = stb_q;
  assign WE_O        = we_q;
  assign MST_O       = mst_q;
  assign ADR_O       = {16'h0000, adr_q};
  assign TGA_O       = tga_q;
  assign DAT_O       = dat_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oError      = err_q;

endmodule

// File: tb/tb_wb_load_sequencer.sv
// Scoreboard bench for wb_load_sequencer: directed row loads, ACK stalls,
// mid-transfer reset and, with WBM_TIMEOUT_EN, the ACK timeout abort.
module tb_wb_load_sequencer;

  logic        CLK_I;
  logic        RST_I;
  logic        iStart;
  logic        iType;
  logic [15:0] iDestBase;
  logic [15:0] iRowCount;
  logic [15:0] iSrcBase;
  logic [15:0] oSrcAddress;
  logic [31:0] iSrcData;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        MST_O;
  logic [31:0] ADR_O;
  logic [1:0]  TGA_O;
  logic [31:0] DAT_O;
  logic        ACK_I;
  logic        oBusy;
  logic        oDone;
  logic        oError;

  wb_load_sequencer #(.TIMEOUT_CYCLES(255)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .iStart(iStart), .iType(iType),
    .iDestBase(iDestBase), .iRowCount(iRowCount), .iSrcBase(iSrcBase),
    .oSrcAddress(oSrcAddress), .iSrcData(iSrcData),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .MST_O(MST_O),
    .ADR_O(ADR_O), .TGA_O(TGA_O), .DAT_O(DAT_O), .ACK_I(ACK_I),
    .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [1:0]  tga;
    logic [31:0] dat;
    logic [15:0] src;
  } beat_t;

  typedef struct packed {
    logic [31:0] cycle;
    logic        err;
  } done_t;

  beat_t       beat_q[$];
  logic [31:0] commit_q[$];
  done_t       done_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int c0         = 0;
  int hold_idx   = -1;
  int hold_extra = 0;
  int ack_count  = 0;
  bit ack_never  = 1'b0;
  logic [31:0] mem [16];

  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  initial begin
    forever begin
      @(posedge CLK_I);
      cyc = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_beat(input logic [31:0] adr, input logic [1:0] tga,
                          input logic [31:0] dat, input logic [15:0] src);
    beat_t b;
    b.adr = adr; b.tga = tga; b.dat = dat; b.src = src;
    beat_q.push_back(b);
  endtask

  task automatic exp_done(input int c, input logic err);
    done_t d;
    d.cycle = 32'(c); d.err = err;
    done_q.push_back(d);
  endtask

  task automatic start(input logic typ, input logic [15:0] dest,
                       input logic [15:0] cnt, input logic [15:0] src);
    @(negedge CLK_I);
    ack_count = 0;
    iStart = 1'b1; iType = typ; iDestBase = dest; iRowCount = cnt; iSrcBase = src;
    @(posedge CLK_I);
    #1;
    c0 = cyc;
    iStart = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((done_q.size() != 0 || oBusy === 1'b1) && n < 1000) begin
      @(negedge CLK_I);
      n = n + 1;
    end
    repeat (2) @(negedge CLK_I);
    check({name, "_done_pending"}, 32'(done_q.size()), 32'd0);
    check({name, "_beats_pending"}, 32'(beat_q.size()), 32'd0);
    check({name, "_commits_pending"}, 32'(commit_q.size()), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctl"}, 32'({CYC_O, STB_O, WE_O, MST_O, oBusy, oDone, oError}), 32'd0);
    check({name, "_adr"}, ADR_O, 32'd0);
    check({name, "_dat"}, DAT_O, 32'd0);
    check({name, "_tga_src"}, 32'({TGA_O, oSrcAddress}), 32'd0);
  endtask

  // Slave model: registered source buffer plus ACK after STB_O, with optional stall.
  initial begin
    logic [15:0] a;
    int stb_cnt;
    int need;
    stb_cnt = 0;
    ACK_I = 1'b0;
    iSrcData = 32'd0;
    forever begin
      @(negedge CLK_I);
      a = oSrcAddress;
      @(posedge CLK_I);
      #1;
      iSrcData = mem[a[3:0]];
      need = (ack_count == hold_idx) ? 1 + hold_extra : 1;
      if (STB_O === 1'b1 && !ack_never) begin
        stb_cnt = stb_cnt + 1;
        if (stb_cnt > need) begin
          ACK_I = 1'b1;
          ack_count = ack_count + 1;
        end else begin
          ACK_I = 1'b0;
        end
      end else begin
        stb_cnt = 0;
        ACK_I = 1'b0;
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a beat, commit or done.
  initial begin
    beat_t       eb;
    done_t       ed;
    logic [31:0] ec;
    logic        p_cyc, p_stb, p_ack, pp_stb;
    logic [31:0] p_adr, p_dat;
    logic [1:0]  p_tga;
    p_cyc = 1'b0; p_stb = 1'b0; p_ack = 1'b0; pp_stb = 1'b0;
    p_adr = 32'd0; p_dat = 32'd0; p_tga = 2'b00;
    forever begin
      @(negedge CLK_I);
      if (RST_I === 1'b0) begin
        if (STB_O === 1'b1 && ACK_I === 1'b1) begin
          check("beat_expected", 32'(beat_q.size() != 0), 32'd1);
          if (beat_q.size() != 0) begin
            eb = beat_q.pop_front();
            check("beat_adr", ADR_O, eb.adr);
            check("beat_tga", 32'(TGA_O), 32'(eb.tga));
            check("beat_dat", DAT_O, eb.dat);
            check("beat_src", 32'(oSrcAddress), 32'(eb.src));
            check("beat_cyc_we", 32'({CYC_O, WE_O}), 32'd3);
          end
        end
        if (MST_O === 1'b1) begin
          check("commit_expected", 32'(commit_q.size() != 0), 32'd1);
          if (commit_q.size() != 0) begin
            ec = commit_q.pop_front();
            check("commit_adr", ADR_O, ec);
            check("commit_cyc_stb_low", 32'({CYC_O, STB_O}), 32'd0);
          end
        end
        if (oDone === 1'b1) begin
          check("done_expected", 32'(done_q.size() != 0), 32'd1);
          if (done_q.size() != 0) begin
            ed = done_q.pop_front();
            check("done_cycle", 32'(cyc - c0 + 1), ed.cycle);
            check("done_error", 32'(oError), 32'(ed.err));
            check("done_bus_idle", 32'({CYC_O, STB_O, MST_O, oBusy}), 32'd0);
          end
        end
        if (p_stb && p_ack) check("stb_drop_after_ack", 32'(STB_O), 32'd0);
        if (CYC_O === 1'b1 && p_cyc) begin
          check("bracket_adr_stable", ADR_O, p_adr);
          check("bracket_tga_stable", 32'(TGA_O), 32'(p_tga));
        end
        if (STB_O === 1'b1 && p_stb && pp_stb) check("dat_hold", DAT_O, p_dat);
        if (CYC_O === 1'b1) check("busy_in_bracket", 32'(oBusy), 32'd1);
      end
      pp_stb = p_stb;
      p_stb  = (STB_O === 1'b1);
      p_ack  = (ACK_I === 1'b1);
      p_cyc  = (CYC_O === 1'b1);
      p_adr  = ADR_O;
      p_dat  = DAT_O;
      p_tga  = TGA_O;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    RST_I = 1'b1; iStart = 1'b0; iType = 1'b0;
    iDestBase = 16'd0; iRowCount = 16'd0; iSrcBase = 16'd0;
    repeat (3) @(negedge CLK_I);
    check_quiet("reset");
    RST_I = 1'b0;

    // One data row; a second iStart while busy must be ignored
    exp_beat(32'h0000_0010, 2'b01, 32'hC0DE_0005, 16'h0005);
    exp_beat(32'h0000_0010, 2'b01, 32'hC0DE_0006, 16'h0006);
    exp_beat(32'h0000_0010, 2'b01, 32'hC0DE_0007, 16'h0007);
    commit_q.push_back(32'h0000_0010);
    exp_done(12, 1'b0);
    start(1'b0, 16'h0010, 16'h0001, 16'h0005);
    @(negedge CLK_I);
    iStart = 1'b1; iType = 1'b1; iRowCount = 16'h0005; iDestBase = 16'h0999;
    @(negedge CLK_I);
    iStart = 1'b0;
    wait_idle("data_row");

    // Two instruction rows from address 0
    exp_beat(32'h0000_0000, 2'b10, 32'hC0DE_0000, 16'h0000);
    exp_beat(32'h0000_0000, 2'b10, 32'hC0DE_0001, 16'h0001);
    exp_beat(32'h0000_0001, 2'b10, 32'hC0DE_0002, 16'h0002);
    exp_beat(32'h0000_0001, 2'b10, 32'hC0DE_0003, 16'h0003);
    commit_q.push_back(32'h0000_0000);
    commit_q.push_back(32'h0000_0001);
    exp_done(17, 1'b0);
    start(1'b1, 16'h0000, 16'h0002, 16'h0000);
    wait_idle("instr_rows");

    // Zero rows: immediate done, bus untouched
    exp_done(1, 1'b0);
    start(1'b0, 16'h0123, 16'h0000, 16'h0004);
    repeat (3) begin
      @(negedge CLK_I);
      check("zero_rows_cyc", 32'(CYC_O), 32'd0);
      check("zero_rows_busy", 32'(oBusy), 32'd0);
    end
    wait_idle("zero_rows");

    // ACK held off 5 extra cycles on beat 2
    hold_idx = 1; hold_extra = 5;
    exp_beat(32'h0000_00FF, 2'b01, 32'hC0DE_000E, 16'h000E);
    exp_beat(32'h0000_00FF, 2'b01, 32'hC0DE_000F, 16'h000F);
    exp_beat(32'h0000_00FF, 2'b01, 32'hC0DE_0000, 16'h0010);
    commit_q.push_back(32'h0000_00FF);
    exp_done(17, 1'b0);
    start(1'b0, 16'h00FF, 16'h0001, 16'h000E);
    wait_idle("ack_stall");
    hold_idx = -1; hold_extra = 0;

    // Row and source addresses wrap at 2^16
    exp_beat(32'h0000_FFFF, 2'b10, 32'hC0DE_000E, 16'hFFFE);
    exp_beat(32'h0000_FFFF, 2'b10, 32'hC0DE_000F, 16'hFFFF);
    exp_beat(32'h0000_0000, 2'b10, 32'hC0DE_0000, 16'h0000);
    exp_beat(32'h0000_0000, 2'b10, 32'hC0DE_0001, 16'h0001);
    commit_q.push_back(32'h0000_FFFF);
    commit_q.push_back(32'h0000_0000);
    exp_done(17, 1'b0);
    start(1'b1, 16'hFFFF, 16'h0002, 16'hFFFE);
    wait_idle("addr_wrap");

    // Reset during the second beat of the first row: partial row dropped
    exp_beat(32'h0000_0020, 2'b01, 32'hC0DE_0003, 16'h0003);
    start(1'b0, 16'h0020, 16'h0002, 16'h0003);
    repeat (6) @(negedge CLK_I);
    check("rst_mid_beat_stb", 32'(STB_O), 32'd1);
    RST_I = 1'b1;
    @(posedge CLK_I);
    #1;
    check_quiet("rst_mid");
    @(negedge CLK_I);
    RST_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    check("rst_no_commit", 32'(MST_O), 32'd0);
    wait_idle("rst_mid");

    exp_beat(32'h0000_0030, 2'b01, 32'hC0DE_0008, 16'h0008);
    exp_beat(32'h0000_0030, 2'b01, 32'hC0DE_0009, 16'h0009);
    exp_beat(32'h0000_0030, 2'b01, 32'hC0DE_000A, 16'h000A);
    commit_q.push_back(32'h0000_0030);
    exp_done(12, 1'b0);
    start(1'b0, 16'h0030, 16'h0001, 16'h0008);
    wait_idle("after_rst");

`ifdef WBM_TIMEOUT_EN
    // ACK never arrives: 255 BEAT cycles then abort with oError
    ack_never = 1'b1;
    exp_done(258, 1'b1);
    start(1'b0, 16'h0040, 16'h0001, 16'h0000);
    wait_idle("timeout");
    check("timeout_error_sticky", 32'(oError), 32'd1);
    check("timeout_bus_idle", 32'({CYC_O, STB_O, WE_O, MST_O}), 32'd0);
    ack_never = 1'b0;
    exp_done(1, 1'b0);
    start(1'b0, 16'h0000, 16'h0000, 16'h0000);
    wait_idle("error_clear");
    check("error_cleared", 32'(oError), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
